// File: rtl/rc_tx_pkg.sv
// Shared constants and helpers for the raised-cosine transmit filters:
// accumulator sizing, saturation limits and a default pulse shape.
package rc_tx_pkg;

  localparam int unsigned DEF_NB_COEFFS = 8;
  localparam int unsigned DEF_N_BAUDS   = 6;
  localparam int unsigned DEF_OS        = 4;

  // Accumulator wide enough for N_BAUDS terms plus negation of the most negative coefficient
  function automatic int unsigned acc_width(input int unsigned nb_coeffs,
                                            input int unsigned n_bauds);
    return nb_coeffs + $clog2(n_bauds) + 1;
  endfunction

  function automatic longint sat_hi(input int unsigned width);
    return (longint'(1) <<< (width - 1)) - longint'(1);
  endfunction

  function automatic longint sat_lo(input int unsigned width);
    return -(longint'(1) <<< (width - 1));
  endfunction

  // Raised cosine, beta 0.5, Q1.7, 6 symbols x 4 samples; coefficient 0 is the LSB byte
  localparam logic [DEF_N_BAUDS*DEF_OS*DEF_NB_COEFFS-1:0] DEF_COEFFS = {
    8'h01, 8'h02, 8'h03, 8'h00, 8'hF9, 8'hF1, 8'hF0, 8'h00,
    8'h21, 8'h4C, 8'h71, 8'h7F, 8'h71, 8'h4C, 8'h21, 8'h00,
    8'hF0, 8'hF1, 8'hF9, 8'h00, 8'h03, 8'h02, 8'h01, 8'h00
  };

endpackage

// File: rtl/rc_sat_round.sv
// Drops NB_DROP fractional LSBs (optionally round-half-up) and saturates
// a signed value to NB_OUT bits. Purely combinational.
module rc_sat_round
  import rc_tx_pkg::*;
#(
  parameter int unsigned NB_IN   = 12,
  parameter int unsigned NB_DROP = 0,
  parameter int unsigned NB_OUT  = 8,
  parameter bit          ROUND   = 1'b0
) (
  input  logic signed [NB_IN-1:0]  value,
  output logic signed [NB_OUT-1:0] result_c
);

  localparam int unsigned NB_EXT = NB_IN + 1;
  localparam int unsigned NB_W   = (NB_EXT > NB_OUT) ? NB_EXT : NB_OUT;

  // Half-LSB offset; collapses to zero when nothing is dropped
  localparam logic signed [NB_EXT-1:0] RND = NB_EXT'(ROUND ? (2 ** NB_DROP) / 2 : 0);
  localparam logic signed [NB_W-1:0]   HI  = NB_W'(sat_hi(NB_OUT));
  localparam logic signed [NB_W-1:0]   LO  = NB_W'(sat_lo(NB_OUT));

  logic signed [NB_EXT-1:0] biased;
  logic signed [NB_W-1:0]   shifted;

  assign biased  = NB_EXT'(value) + RND;
  assign shifted = NB_W'(biased >>> NB_DROP);

  assign result_c = (shifted > HI) ? NB_OUT'(HI) :
                    (shifted < LO) ? NB_OUT'(LO) : NB_OUT'(shifted);

endmodule

// File: rtl/rc_tx_poly.sv
// Polyphase BPSK raised-cosine transmit filter: one symbol in per OS clocks,
// one sample out per enabled clock. Define RC_TX_POLY_ROUND_EN to round instead of truncate.
module rc_tx_poly
  import rc_tx_pkg::*;
#(
  parameter int unsigned NB_COEFFS  = DEF_NB_COEFFS,
  parameter int unsigned NBF_COEFFS = 7,
  parameter int unsigned NB_OUTPUT  = 8,
  parameter int unsigned NBF_OUTPUT = 7,
  parameter int unsigned N_BAUDS    = DEF_N_BAUDS,
  parameter int unsigned OS         = DEF_OS
) (
  input  logic                                clock,
  input  logic                                i_reset,
  input  logic                                i_enable,
  input  logic                                i_sym_valid,
  input  logic                                i_sym,
  output logic                                o_sym_ready,
  input  logic [N_BAUDS*OS*NB_COEFFS-1:0]     i_coeffs,
  output logic signed [NB_OUTPUT-1:0]         o_sample,
  output logic                                o_valid,
  output logic                                o_underrun
);

  localparam int unsigned NB_ACC = acc_width(NB_COEFFS, N_BAUDS);
  localparam int unsigned NB_PH  = $clog2(OS);

`ifdef RC_TX_POLY_ROUND_EN
  localparam bit ROUND_EN = 1'b1;
`else
  localparam bit ROUND_EN = 1'b0;
`endif

  logic [NB_PH-1:0]           phase;
  logic [N_BAUDS-1:0]         tap_sym;
  logic [N_BAUDS-1:0]         tap_vld;
  logic signed [NB_ACC-1:0]   acc_c;
  logic signed [NB_OUTPUT-1:0] sat_c;
  logic signed [NB_COEFFS-1:0] coef [N_BAUDS][OS];

  // Rearrange the flat coefficient bus into [symbol tap][phase]
  for (genvar k = 0; k < N_BAUDS; k++) begin : g_tap
    for (genvar p = 0; p < OS; p++) begin : g_phase
      assign coef[k][p] = i_coeffs[(k*OS + p)*NB_COEFFS +: NB_COEFFS];
    end
  end

  assign o_sym_ready = i_enable & (phase == NB_PH'(OS - 1));

  always_comb begin
    acc_c = '0;
    for (int k = 0; k < N_BAUDS; k++) begin
      if (tap_vld[k]) begin
        if (tap_sym[k]) acc_c = acc_c + NB_ACC'(coef[k][phase]);
        else            acc_c = acc_c - NB_ACC'(coef[k][phase]);
      end
    end
  end

  rc_sat_round #(
    .NB_IN   (NB_ACC),
    .NB_DROP (NBF_COEFFS - NBF_OUTPUT),
    .NB_OUT  (NB_OUTPUT),
    .ROUND   (ROUND_EN)
  ) u_sat_round (
    .value    (acc_c),
    .result_c (sat_c)
  );

  // Delay line, phase and output register; everything freezes while disabled
  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      phase      <= '0;
      tap_sym    <= '0;
      tap_vld    <= '0;
      o_sample   <= '0;
      o_valid    <= 1'b0;
      o_underrun <= 1'b0;
    end else begin
      o_valid <= i_enable;
      if (i_enable) begin
        phase    <= (phase == NB_PH'(OS - 1)) ? '0 : phase + 1'b1;
        o_sample <= sat_c;
        if (o_sym_ready) begin
          tap_sym <= {tap_sym[N_BAUDS-2:0], i_sym};
          tap_vld <= {tap_vld[N_BAUDS-2:0], i_sym_valid};
          if (!i_sym_valid) o_underrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rc_tx_poly.sv
// Directed bench for rc_tx_poly: impulse ramp, enable freeze, async reset,
// saturation, output LSB drop on a second instance, and a random-symbol run.
module tb_rc_tx_poly;
  import rc_tx_pkg::*;

  localparam int unsigned NBC = 8;
  localparam int unsigned NBD = 6;
  localparam int unsigned OSF = 4;
  localparam int unsigned NT  = NBD * OSF;

  logic                 clock;
  logic                 i_reset;
  logic                 i_enable;
  logic                 i_sym_valid;
  logic                 i_sym;
  logic                 o_sym_ready;
  logic [NT*NBC-1:0]    coeffs;
  logic signed [7:0]    o_sample;
  logic                 o_valid;
  logic                 o_underrun;

  logic                 sym_valid6;
  logic                 sym6;
  logic                 ready6;
  logic [NT*NBC-1:0]    coeffs6;
  logic signed [7:0]    sample6;
  logic                 valid6;
  logic                 underrun6;

  int total = 0;
  int bad   = 0;

  int ph_m;
  bit sym_m [NBD];
  bit vld_m [NBD];

  rc_tx_poly dut (
    .clock       (clock),
    .i_reset     (i_reset),
    .i_enable    (i_enable),
    .i_sym_valid (i_sym_valid),
    .i_sym       (i_sym),
    .o_sym_ready (o_sym_ready),
    .i_coeffs    (coeffs),
    .o_sample    (o_sample),
    .o_valid     (o_valid),
    .o_underrun  (o_underrun)
  );

  rc_tx_poly #(.NBF_OUTPUT(6)) dut6 (
    .clock       (clock),
    .i_reset     (i_reset),
    .i_enable    (i_enable),
    .i_sym_valid (sym_valid6),
    .i_sym       (sym6),
    .o_sym_ready (ready6),
    .i_coeffs    (coeffs6),
    .o_sample    (sample6),
    .o_valid     (valid6),
    .o_underrun  (underrun6)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic int model_out();
    int s = 0;
    for (int k = 0; k < int'(NBD); k++) begin
      if (vld_m[k]) begin
        int c = int'($signed(coeffs[(k*int'(OSF) + ph_m)*int'(NBC) +: NBC]));
        s += sym_m[k] ? c : -c;
      end
    end
    if (s > 127)  s = 127;
    if (s < -128) s = -128;
    return s;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int exp6;
    int exp_sample;
    int acc_seen;
    int acc_model;
    bit en;
    bit sym;

`ifdef RC_TX_POLY_ROUND_EN
    exp6 = 2;
`else
    exp6 = 1;
`endif

    i_reset     = 1'b1;
    i_enable    = 1'b0;
    i_sym_valid = 1'b0;
    i_sym       = 1'b0;
    sym_valid6  = 1'b1;
    sym6        = 1'b1;
    coeffs6     = '0;
    coeffs6[7:0] = 8'h03;
    for (int c = 0; c < int'(NT); c++) coeffs[c*int'(NBC) +: NBC] = 8'(c + 1);
    step();
    step();
    i_reset = 1'b0;

    check("rst_sample",   int'(o_sample),   0);
    check("rst_valid",    int'(o_valid),    0);
    check("rst_underrun", int'(o_underrun), 0);
    check("rst_ready",    int'(o_sym_ready), 0);

    // Impulse through the ramp coefficients, with a 5-cycle enable gap
    i_enable = 1'b1;
    check("ready_ph0", int'(o_sym_ready), 0);
    repeat (3) step();
    check("ready_ph3", int'(o_sym_ready), 1);
    check("no_flag_off_phase", int'(o_underrun), 0);
    i_sym_valid = 1'b1;
    i_sym       = 1'b1;
    step();
    check("empty_out", int'(o_sample), 0);
    i_sym_valid = 1'b0;
    i_sym       = 1'b0;
    for (int n = 1; n <= 24; n++) begin
      step();
      check($sformatf("ramp_%0d", n), int'(o_sample), n);
      if (n == 10) begin
        i_enable = 1'b0;
        for (int d = 0; d < 5; d++) begin
          step();
          check("hold_valid",  int'(o_valid),     0);
          check("hold_sample", int'(o_sample),    10);
          check("hold_ready",  int'(o_sym_ready), 0);
        end
        i_enable = 1'b1;
      end
    end
    step();
    check("ramp_tail",  int'(o_sample),   0);
    check("underrun",   int'(o_underrun), 1);
    check("valid_on",   int'(o_valid),    1);

    // Full-scale coefficients, then async reset between edges
    for (int c = 0; c < int'(NT); c++) coeffs[c*int'(NBC) +: NBC] = 8'h7F;
    i_sym_valid = 1'b1;
    i_sym       = 1'b1;
    repeat (8) step();
    check("pre_rst_sat", int'(o_sample), 127);
    @(posedge clock);
    #3;
    i_reset = 1'b1;
    #1;
    check("arst_sample",   int'(o_sample),    0);
    check("arst_valid",    int'(o_valid),     0);
    check("arst_underrun", int'(o_underrun),  0);
    check("arst_ready",    int'(o_sym_ready), 0);
    #1;
    i_reset = 1'b0;
    check("rel_ready_0", int'(o_sym_ready), 0);
    step();
    check("rel_ready_1", int'(o_sym_ready), 0);
    step();
    check("rel_ready_2", int'(o_sym_ready), 0);
    step();
    check("rel_ready_3", int'(o_sym_ready), 1);
    step();
    step();
    check("first_sym_out", int'(o_sample), 127);
    check("drop_lsb",      int'(sample6),  exp6);
    repeat (40) step();
    check("sat_pos", int'(o_sample), 127);
    i_sym = 1'b0;
    repeat (40) step();
    check("sat_neg", int'(o_sample), -128);
    check("no_underrun", int'(o_underrun), 0);

    // Random symbols against the bench model, default pulse shape
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    coeffs = DEF_COEFFS;
    ph_m = 0;
    for (int k = 0; k < int'(NBD); k++) begin
      sym_m[k] = 1'b0;
      vld_m[k] = 1'b0;
    end
    i_sym_valid = 1'b1;
    exp_sample  = 0;
    acc_seen    = 0;
    acc_model   = 0;
    for (int i = 0; i < 200; i++) begin
      en  = (i % 13) != 7;
      sym = 1'($urandom_range(0, 1));
      i_enable = en;
      i_sym    = sym;
      #1;
      check("rnd_ready", int'(o_sym_ready), int'(en && ph_m == int'(OSF) - 1));
      if (o_sym_ready && i_sym_valid) acc_seen++;
      if (en) begin
        exp_sample = model_out();
        if (ph_m == int'(OSF) - 1) begin
          for (int k = int'(NBD) - 1; k > 0; k--) begin
            sym_m[k] = sym_m[k-1];
            vld_m[k] = vld_m[k-1];
          end
          sym_m[0] = sym;
          vld_m[0] = 1'b1;
          acc_model++;
        end
        ph_m = (ph_m + 1) % int'(OSF);
      end
      step();
      check("rnd_sample", int'(o_sample), exp_sample);
      check("rnd_valid",  int'(o_valid),  int'(en));
    end
    check("rnd_accepts", acc_seen, acc_model);
    check("rnd_no_underrun", int'(o_underrun), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
